regblock_port_arbiter: RTL and testbench
========================================

Name: regblock_port_arbiter

Overview:
- Shares the single read port and single write port of the 40-entry register block among NUM_REQ requesters, using independent round-robin arbitration for reads and writes.
- The write path to the register block is combinational, so the selected write lands at the next clock edge. Read data returns one cycle after grant as a registered response, with same-cycle write-to-read forwarding.
- Out-of-range addresses are flagged as errors.
- Sits between the requester logic and the register block's readregsel/readdata/writeregsel/writedata/write pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BITWIDTH, 11, register data width
NUM_REGS, 40, number of implemented registers; addresses >= NUM_REGS are errors
ADDR_W, 6, address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
wr_req  in  NUM_REQ  per-requester write request
wr_addr  in  NUM_REQ*ADDR_W  write addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
wr_data  in  NUM_REQ*BITWIDTH  write data, sliced the same way
wr_gnt  out  NUM_REQ  one-hot write grant (combinational)
wr_err  out  NUM_REQ  registered one-cycle pulse; granted write had an out-of-range address
rd_req  in  NUM_REQ  per-requester read request
rd_addr  in  NUM_REQ*ADDR_W  read addresses
rd_gnt  out  NUM_REQ  one-hot read grant (combinational)
rd_rsp_valid  out  NUM_REQ  registered one-hot; response for requester i
rd_rsp_data  out  BITWIDTH  registered read data
rd_rsp_err  out  1  registered; response was for an out-of-range address
rb_write  out  1  to register block write
rb_writeregsel  out  ADDR_W  to register block writeregsel
rb_writedata  out  BITWIDTH  to register block writedata
rb_readregsel  out  ADDR_W  to register block readregsel
rb_readdata  in  BITWIDTH  from register block readdata

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0, wr_err=0. While rst=0, wr_gnt, rd_gnt and rb_write are forced to 0. Reset asserted mid-response drops that response; no retry.
- Arbitration, identical for reads and writes and independent per side: search from the pointer upward, wrapping modulo NUM_REQ. The first requester with req=1 gets the grant. At most one grant per side per cycle. No request means no grant and the pointer holds.
- Pointer update at the clock edge: after granting requester g, ptr <= (g+1) mod NUM_REQ.
- Grant means the request is consumed that cycle. A requester that holds req high re-arbitrates next cycle.
- Write path (combinational):
  - rb_writeregsel = granted wr_addr; rb_writedata = granted wr_data.
  - rb_write = 1 only if a grant exists and addr < NUM_REGS.
  - With no grant, rb_writeregsel and rb_writedata are 0.
- Write error: out-of-range granted write gives rb_write=0, and wr_err[g]=1 for exactly the next cycle.
- Read path:
  - rb_readregsel = granted rd_addr, or 0 with no grant.
  - At the edge: rd_rsp_valid <= one-hot of the grant, or 0 with no grant.
  - rd_rsp_err <= (addr >= NUM_REGS).
  - rd_rsp_data <= 0 if err; else forwarded write data if forwarding applies; else rb_readdata.
  - Latency is exactly 1 cycle from rd_gnt to rd_rsp_valid. A new read may be granted every cycle.
- Forwarding: a read granted in the same cycle as an in-range write to the same address returns the new write data, not the old register contents.
- rd_rsp_data holds its last value when rd_rsp_valid=0.
- Read and write by the same requester in the same cycle are allowed; both can be granted.
- Address width: compare full ADDR_W bits; no truncation. Address 6'd40..6'd63 are errors.

Test Plan:
- Reset, then req0 writes addr 5 = 11'h2A5; next cycle req0 reads addr 5 -> rb_write=1 with writeregsel=5 in the write cycle; rd_rsp_valid=4'b0001 and rd_rsp_data=11'h2A5 one cycle after rd_gnt.
- All four wr_req held high for 8 cycles with ptr=0 -> wr_gnt sequence 0001,0010,0100,1000,0001,... ; then only req2 requesting -> grant 0100 every cycle.
- Same cycle: req1 writes addr 39 = 11'h7FF and req3 reads addr 39 (old value 11'h011) -> rd_rsp_valid=4'b1000, rd_rsp_data=11'h7FF (forwarded).
- req0 writes addr 40 and req2 reads addr 63 -> rb_write=0; next cycle wr_err=4'b0001, rd_rsp_valid=4'b0100, rd_rsp_err=1, rd_rsp_data=0.
- Grant to req2 (ptr advances to 3), then rst pulsed low mid-cycle -> all registered outputs 0 immediately; wr_gnt=rd_gnt=0 during reset; after release, requests from 1 and 3 -> first grant goes to req1 (ptr=0).

Source files
------------

// File: rtl/regblock_port_arbiter.sv
// Round-robin sharing of the register block's single read and single write port
// among NUM_REQ requesters, with range checking and write-to-read forwarding.
module regblock_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int BITWIDTH = 11,
   parameter int NUM_REGS = 40,
   parameter int ADDR_W   = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           wr_req,
   input  logic [NUM_REQ*ADDR_W-1:0]    wr_addr,
   input  logic [NUM_REQ*BITWIDTH-1:0]  wr_data,
   output logic [NUM_REQ-1:0]           wr_gnt,
   output logic [NUM_REQ-1:0]           wr_err,
   input  logic [NUM_REQ-1:0]           rd_req,
   input  logic [NUM_REQ*ADDR_W-1:0]    rd_addr,
   output logic [NUM_REQ-1:0]           rd_gnt,
   output logic [NUM_REQ-1:0]           rd_rsp_valid,
   output logic [BITWIDTH-1:0]          rd_rsp_data,
   output logic                         rd_rsp_err,
   output logic                         rb_write,
   output logic [ADDR_W-1:0]            rb_writeregsel,
   output logic [BITWIDTH-1:0]          rb_writedata,
   output logic [ADDR_W-1:0]            rb_readregsel,
   input  logic [BITWIDTH-1:0]          rb_readdata
);

   localparam int PTR_W = $clog2(NUM_REQ);
   // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PTR_W-1:0]    wr_sel, rd_sel;
   logic                wr_found, rd_found;
   logic                wr_any, rd_any;
   logic                rd_in_range, fwd;
   logic [ADDR_W-1:0]   wr_addr_g, rd_addr_g;
   logic [BITWIDTH-1:0] wr_data_g;

   // Returns {found, index} of the first requester at or after ptr, wrapping.
   function automatic logic [PTR_W:0] arbitrate(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
      logic             found;
      logic [PTR_W-1:0] sel;
      logic [PTR_W-1:0] cand;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      return {found, sel};
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] sel);
      return (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
   endfunction

   assign {wr_found, wr_sel} = arbitrate(wr_req, wr_ptr);
   assign {rd_found, rd_sel} = arbitrate(rd_req, rd_ptr);

   // Grants are suppressed while reset is held so nothing reaches the register block.
   assign wr_gnt = (rst && wr_found) ? (NUM_REQ'(1) << wr_sel) : '0;
   assign rd_gnt = (rst && rd_found) ? (NUM_REQ'(1) << rd_sel) : '0;
   assign wr_any = |wr_gnt;
   assign rd_any = |rd_gnt;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      wr_addr_g = '0;
      wr_data_g = '0;
      rd_addr_g = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_gnt[i]) begin
            wr_addr_g = wr_addr[i*ADDR_W +: ADDR_W];
            wr_data_g = wr_data[i*BITWIDTH +: BITWIDTH];
         end
         if (rd_gnt[i]) begin
            rd_addr_g = rd_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign rb_write       = wr_any && ({1'b0, wr_addr_g} < LIMIT);
   assign rb_writeregsel = wr_addr_g;
   assign rb_writedata   = wr_data_g;
   assign rb_readregsel  = rd_addr_g;

   assign rd_in_range = {1'b0, rd_addr_g} < LIMIT;
   // The register block only commits the write at the edge, so a same-cycle read must bypass it.
   assign fwd         = rb_write && rd_any && (wr_addr_g == rd_addr_g);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         wr_err       <= '0;
         rd_rsp_valid <= '0;
         rd_rsp_data  <= '0;
         rd_rsp_err   <= 1'b0;
      end else begin
         if (wr_any) wr_ptr <= ptr_next(wr_sel);
         if (rd_any) rd_ptr <= ptr_next(rd_sel);
         wr_err       <= (wr_any && !rb_write) ? wr_gnt : '0;
         rd_rsp_valid <= rd_gnt;
         rd_rsp_err   <= rd_any && !rd_in_range;
         if (rd_any) begin
            if (!rd_in_range) rd_rsp_data <= '0;
            else if (fwd)     rd_rsp_data <= wr_data_g;
            else              rd_rsp_data <= rb_readdata;
         end
      end
   end

endmodule

// File: tb/tb_regblock_port_arbiter.sv
// Bench for regblock_port_arbiter: a register-block model on the rb_* pins and a
// queue-free reference model of round-robin grants, register contents and responses.
module tb_regblock_port_arbiter;

   localparam int N  = 4;
   localparam int BW = 11;
   localparam int NR = 40;
   localparam int AW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    wr_req, rd_req;
   logic [N*AW-1:0] wr_addr, rd_addr;
   logic [N*BW-1:0] wr_data;
   logic [N-1:0]    wr_gnt, wr_err, rd_gnt, rd_rsp_valid;
   logic [BW-1:0]   rd_rsp_data;
   logic            rd_rsp_err;
   logic            rb_write;
   logic [AW-1:0]   rb_writeregsel, rb_readregsel;
   logic [BW-1:0]   rb_writedata, rb_readdata;

   regblock_port_arbiter #(.NUM_REQ(N), .BITWIDTH(BW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_gnt         (wr_gnt),
      .wr_err         (wr_err),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_gnt         (rd_gnt),
      .rd_rsp_valid   (rd_rsp_valid),
      .rd_rsp_data    (rd_rsp_data),
      .rd_rsp_err     (rd_rsp_err),
      .rb_write       (rb_write),
      .rb_writeregsel (rb_writeregsel),
      .rb_writedata   (rb_writedata),
      .rb_readregsel  (rb_readregsel),
      .rb_readdata    (rb_readdata)
   );

   always #5 clk = ~clk;

   // Register block: combinational read, write committed at the clock edge.
   logic [BW-1:0] rf [0:63];
   always @(posedge clk) if (rb_write) rf[rb_writeregsel] <= rb_writedata;
   assign rb_readdata = rf[rb_readregsel];

   int            checks = 0;
   int            errors = 0;
   int            m_wr_ptr, m_rd_ptr;
   logic [BW-1:0] m_regs [0:63];
   logic [BW-1:0] m_last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int arb(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   function automatic int rand_addr();
      int r;
      r = int'($urandom % 8);
      if (r == 0) return NR + int'($urandom % 24);
      if (r < 4)  return int'($urandom % 3);
      return int'($urandom % NR);
   endfunction

   task automatic idle();
      wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
   endtask

   task automatic set_wr(input int i, input int a, input int d);
      wr_req[i] = 1'b1;
      wr_addr[i*AW +: AW] = AW'(a);
      wr_data[i*BW +: BW] = BW'(d);
   endtask

   task automatic set_rd(input int i, input int a);
      rd_req[i] = 1'b1;
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   // One arbitration cycle: combinational checks before the edge, registered checks after.
   task automatic cycle();
      int wg, rg, waddr, raddr, wdata;
      logic ew, er;
      logic [N-1:0] exp_wr_err, exp_valid;
      @(negedge clk);
      wg = arb(wr_req, m_wr_ptr);
      rg = arb(rd_req, m_rd_ptr);
      waddr = (wg >= 0) ? int'(wr_addr[wg*AW +: AW]) : 0;
      wdata = (wg >= 0) ? int'(wr_data[wg*BW +: BW]) : 0;
      raddr = (rg >= 0) ? int'(rd_addr[rg*AW +: AW]) : 0;
      ew = (wg >= 0) && (waddr < NR);
      er = (rg >= 0) && (raddr >= NR);
      check("wr_gnt", wr_gnt, (wg >= 0) ? (1 << wg) : 0);
      check("rd_gnt", rd_gnt, (rg >= 0) ? (1 << rg) : 0);
      check("rb_write", rb_write, ew);
      check("rb_writeregsel", rb_writeregsel, waddr);
      check("rb_writedata", rb_writedata, wdata);
      check("rb_readregsel", rb_readregsel, raddr);
      if (ew) m_regs[waddr] = BW'(wdata);
      if (rg >= 0) m_last_data = er ? '0 : m_regs[raddr];
      exp_valid  = (rg >= 0) ? N'(1 << rg) : '0;
      exp_wr_err = (wg >= 0 && !ew) ? N'(1 << wg) : '0;
      if (wg >= 0) m_wr_ptr = (wg + 1) % N;
      if (rg >= 0) m_rd_ptr = (rg + 1) % N;
      @(posedge clk);
      #1;
      check("rd_rsp_valid", rd_rsp_valid, exp_valid);
      check("rd_rsp_err", rd_rsp_err, er);
      check("rd_rsp_data", rd_rsp_data, m_last_data);
      check("wr_err", wr_err, exp_wr_err);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_rd_rsp_valid", rd_rsp_valid, 0);
      check("rst_rd_rsp_data", rd_rsp_data, 0);
      check("rst_rd_rsp_err", rd_rsp_err, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_rb_write", rb_write, 0);
      m_wr_ptr = 0;
      m_rd_ptr = 0;
      m_last_data = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      do_reset();

      // Load every implemented register through the arbiter; address 39 holds 11'h011.
      for (int a = 0; a < NR; a++) begin
         idle();
         set_wr(a % N, a, (a == 39) ? 'h011 : int'($urandom));
         cycle();
      end

      // Write then read back address 5 from requester 0.
      do_reset();
      set_wr(0, 5, 'h2A5);
      cycle();
      idle();
      set_rd(0, 5);
      cycle();
      check("t1_valid", rd_rsp_valid, 4'b0001);
      check("t1_data", rd_rsp_data, 11'h2A5);

      // Rotation with all writers active, then a lone requester 2.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         idle();
         for (int i = 0; i < N; i++) set_wr(i, int'($urandom % 30), int'($urandom));
         cycle();
      end
      for (int c = 0; c < 4; c++) begin
         idle();
         set_wr(2, int'($urandom % 30), int'($urandom));
         cycle();
      end

      // Same-cycle write and read of address 39 must forward the new data.
      idle();
      set_wr(1, 39, 'h7FF);
      set_rd(3, 39);
      cycle();
      check("fwd_valid", rd_rsp_valid, 4'b1000);
      check("fwd_data", rd_rsp_data, 11'h7FF);

      // Out-of-range write and read.
      idle();
      set_wr(0, 40, 'h123);
      set_rd(2, 63);
      cycle();
      check("oor_wr_err", wr_err, 4'b0001);
      check("oor_rd_err", rd_rsp_err, 1'b1);
      check("oor_rd_data", rd_rsp_data, 0);
      idle();
      cycle();

      // Reset in the middle of an outstanding response.
      idle();
      set_wr(2, 3, 'h055);
      set_rd(2, 7);
      cycle();
      wr_req = '1;
      rd_req = '1;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", rd_rsp_valid, 0);
      check("mid_rst_data", rd_rsp_data, 0);
      check("mid_rst_wr_gnt", wr_gnt, 0);
      check("mid_rst_rd_gnt", rd_gnt, 0);
      do_reset();
      set_wr(1, 10, 'h3C3);
      set_wr(3, 11, 'h1E1);
      set_rd(1, 10);
      set_rd(3, 11);
      cycle();
      check("post_rst_valid", rd_rsp_valid, 4'b0010);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int i = 0; i < N; i++) begin
            if ($urandom % 2 == 1) set_wr(i, rand_addr(), int'($urandom));
            if ($urandom % 2 == 1) set_rd(i, rand_addr());
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
